// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-SRAM access sequencer (IDLE/REQ/DONE) with load alignment/extension.
// Optional feature: define MEM_ALIGN_CHECK_EN to raise address-error exceptions on misaligned half/word accesses.
module mem_access_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_din,
  input  logic [4:0]  mem_exccode,
  input  logic        flush,
  output logic        dsram_req,
  output logic        dsram_we,
  output logic [3:0]  dsram_be,
  output logic [31:0] dsram_addr,
  output logic [31:0] dsram_wdata,
  input  logic        dsram_ack,
  input  logic [31:0] dsram_rdata,
  output logic        stall_req_mem,
  output logic [31:0] ld_data,
  output logic [4:0]  exccode_o,
  output logic [31:0] badvaddr
);
  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;

  logic        is_byte, is_half, is_word, is_st, is_acc, mis, go;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_byte = mem_aluop == OP_LB || mem_aluop == OP_LBU || mem_aluop == OP_SB;
  assign is_half = mem_aluop == OP_LH || mem_aluop == OP_LHU || mem_aluop == OP_SH;
  assign is_word = mem_aluop == OP_LW || mem_aluop == OP_SW;
  assign is_st   = mem_aluop == OP_SB || mem_aluop == OP_SH || mem_aluop == OP_SW;
  assign is_acc  = is_byte || is_half || is_word;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = ((is_half && mem_wd[0]) || (is_word && mem_wd[1:0] != 2'b00)) && mem_exccode == EXC_NONE;
`else
  assign mis = 1'b0;
`endif

  assign go     = is_acc && mem_exccode == EXC_NONE && !flush && !mis;
  assign be_new = is_byte ? 4'b0001 << mem_wd[1:0] : is_half ? 4'b0011 << {mem_wd[1], 1'b0} : 4'b1111;
  assign wd_new = is_byte ? {4{mem_din[7:0]}} : is_half ? {2{mem_din[15:0]}} : mem_din;

  // State and request/capture registers; reset abandons any transaction in flight.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rword_q <= 32'b0;
      op_q    <= 8'b0;
      lo_q    <= 2'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: launch in IDLE, hold until ack in REQ, one DONE cycle unless the access was flushed.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    op_d    = op_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = REQ;
        kill_d  = 1'b0;
        req_d   = 1'b1;
        we_d    = is_st;
        be_d    = be_new;
        addr_d  = {mem_wd[31:2], 2'b00};
        wdata_d = wd_new;
        op_d    = mem_aluop;
        lo_d    = mem_wd[1:0];
      end
      REQ: begin
        kill_d = kill_q || flush;
        if (dsram_ack) begin
          state_d = (kill_q || flush) ? IDLE : DONE;
          kill_d  = 1'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0;
          addr_d  = 32'b0;
          wdata_d = 32'b0;
          rword_d = dsram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lane_b = rword_q[{lo_q, 3'b000} +: 8];
  assign lane_h = lo_q[1] ? rword_q[31:16] : rword_q[15:0];

  // Load result: lane select plus sign/zero extension, only presented in DONE.
  always_comb begin
    ld_data = 32'b0;
    if (state_q == DONE)
      ld_data = op_q == OP_LB  ? {{24{lane_b[7]}}, lane_b} :
                op_q == OP_LBU ? {24'b0, lane_b} :
                op_q == OP_LH  ? {{16{lane_h[15]}}, lane_h} :
                op_q == OP_LHU ? {16'b0, lane_h} :
                op_q == OP_LW  ? rword_q : 32'b0;
  end

  assign dsram_req     = req_q;
  assign dsram_we      = we_q;
  assign dsram_be      = be_q;
  assign dsram_addr    = addr_q;
  assign dsram_wdata   = wdata_q;
  assign stall_req_mem = cpu_rst_n && ((state_q == IDLE && go) || state_q == REQ);
  assign exccode_o     = mis ? (is_st ? EXC_ADES : EXC_ADEL) : mem_exccode;
  assign badvaddr      = (cpu_rst_n && mis) ? mem_wd : 32'b0;
endmodule
